// File: rtl/fifo_pkg.sv
// Shared widths, burst sizing helper and reader state encoding for the FIFO burst reader.
package fifo_pkg;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int BURST_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } rd_state_e;

  // A programmed length of zero selects a full-depth burst.
  function automatic logic [BURST_W-1:0] burst_count(input logic [BURST_W-1:0] len);
    return (len == '0) ? BURST_W'(DEPTH) : len;
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// Single-entry output register: a loaded word appears as valid one cycle later and
// data/last/valid hold while the sink withholds ready; ready_o says a load will be taken.
module fifo_out_reg
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  // Slot is free when empty or when its current beat leaves this cycle.
  assign ready_o = ~valid_q | ready_i;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_i && ready_o) begin
      data_d  = data_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      last_d  = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fifo_reader.sv
// Burst reader draining a first-word-fall-through FIFO into a valid/ready stream, pop-to-valid 1 cycle.
// Pops pause on empty FIFO or stream backpressure; FIFO_READER_STATS_EN adds a handshake counter.
module fifo_reader
  import fifo_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  fifo_data,
  input  logic               fifo_empty,
  input  logic               fifo_threshold,
  input  logic               kick,
  input  logic [BURST_W-1:0] burst_len,
  output logic               rd,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
`ifdef FIFO_READER_STATS_EN
  output logic [15:0]        beat_cnt,
`endif
  output logic [7:0]         stall_cnt
);

  rd_state_e          state_q, state_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [7:0]         stall_q, stall_d;
  logic               slot_free;
  logic               last_beat;

  assign last_beat = (remaining_q == BURST_W'(1));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    stall_d     = stall_q;
    rd          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((fifo_threshold | kick) & ~fifo_empty) begin
          state_d     = BURST;
          remaining_d = burst_count(burst_len);
        end
      end
      BURST: begin
        if (remaining_q != '0) begin
          rd = ~fifo_empty & slot_free;
          if (fifo_empty && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'd1;
          end
        end
        if (rd) begin
          remaining_d = remaining_q - BURST_W'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (m_valid & m_ready & m_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle must not consume a FIFO word that would be discarded anyway.
    if (rst) begin
      rd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      stall_q     <= stall_d;
    end
  end

  fifo_out_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (rd),
    .data_i  (fifo_data),
    .last_i  (last_beat),
    .ready_i (m_ready),
    .ready_o (slot_free),
    .data_o  (m_data),
    .last_o  (m_last),
    .valid_o (m_valid)
  );

  assign busy      = (state_q != IDLE);
  assign stall_cnt = stall_q;

`ifdef FIFO_READER_STATS_EN
  logic [15:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (m_valid && m_ready) begin
      beat_d = beat_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: cycle table for the first bursts, then sequences for
// stalls, backpressure, mid-burst reset and empty-FIFO kick.
module tb_fifo_reader;

  logic       clk;
  logic       rst;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_threshold;
  logic       kick;
  logic [4:0] burst_len;
  logic       rd;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
  logic [7:0] stall_cnt;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] beat_cnt;
`endif

  fifo_reader dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .kick           (kick),
    .burst_len      (burst_len),
    .rd             (rd),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .busy           (busy),
`ifdef FIFO_READER_STATS_EN
    .beat_cnt       (beat_cnt),
`endif
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] fifo_q[$];
  logic [8:0] rx_q[$];
  logic       rd_s;
  logic       hold_q = 1'b0;
  logic [8:0] hold_beat = '0;
  int         hold_seen = 0;

  typedef struct packed {
    logic       kick;
    logic       rdy;
    logic       rd;
    logic       busy;
    logic       valid;
    logic       last;
    logic [7:0] data;
  } vec_t;

  vec_t vec[14];

  function automatic vec_t mk(input logic k, input logic r, input logic x_rd, input logic b,
                              input logic v, input logic l, input logic [7:0] d);
    vec_t t;
    t = {k, r, x_rd, b, v, l, d};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bench-side FIFO model: head word is presented whenever non-empty.
  task automatic refresh();
    fifo_empty     = (fifo_q.size() == 0);
    fifo_data      = fifo_empty ? 8'h00 : fifo_q[0];
    fifo_threshold = (fifo_q.size() >= 8);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  task automatic flush();
    fifo_q.delete();
    refresh();
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    rd_s = rd;
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic cycle();
    to_neg();
    finish_cycle();
  endtask

  task automatic wait_beats(input string name, input int n, input int max_cyc, input logic [3:0] pat);
    int k;
    k = 0;
    while (!((rx_q.size() >= n) && !busy) && (k < max_cyc)) begin
      m_ready = pat[k % 4];
      cycle();
      k++;
    end
    m_ready = 1'b1;
    chk({name, " completes in budget"}, 32'(k < max_cyc), 32'd1);
  endtask

  task automatic check_rx(input string name, input logic [7:0] first, input int n);
    logic [8:0] e;
    chk({name, " beat count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      e = {(i == n - 1), 8'(int'(first) + i)};
      chk($sformatf("%s beat %0d {last,data}", name, i), 32'(rx_q[i]), 32'(e));
    end
  endtask

  // Stream monitor: records handshakes, checks hold under backpressure and legal pops.
  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold valid", 32'(m_valid), 32'd1);
        chk("hold {last,data}", 32'({m_last, m_data}), 32'(hold_beat));
      end
      if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
      chk("rd legal", 32'(rd && (fifo_empty || !busy || (m_valid && !m_ready))), 32'd0);
      hold_q    = m_valid && !m_ready;
      hold_beat = {m_last, m_data};
      if (hold_q) hold_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    kick      = 1'b0;
    m_ready   = 1'b1;
    burst_len = 5'd4;
    flush();

    // kick, rdy | rd, busy, valid, last, data
    vec[0]  = mk(0, 1, 0, 0, 0, 0, 8'h00);
    vec[1]  = mk(0, 1, 1, 1, 0, 0, 8'h00);
    vec[2]  = mk(0, 1, 1, 1, 1, 0, 8'h01);
    vec[3]  = mk(0, 1, 1, 1, 1, 0, 8'h02);
    vec[4]  = mk(0, 1, 1, 1, 1, 0, 8'h03);
    vec[5]  = mk(0, 1, 0, 1, 1, 1, 8'h04);
    vec[6]  = mk(0, 1, 0, 0, 0, 0, 8'h00);
    vec[7]  = mk(1, 1, 0, 0, 0, 0, 8'h00);
    vec[8]  = mk(0, 1, 1, 1, 0, 0, 8'h00);
    vec[9]  = mk(0, 1, 1, 1, 1, 0, 8'h05);
    vec[10] = mk(0, 1, 1, 1, 1, 0, 8'h06);
    vec[11] = mk(0, 1, 1, 1, 1, 0, 8'h07);
    vec[12] = mk(0, 1, 0, 1, 1, 1, 8'h08);
    vec[13] = mk(0, 1, 0, 0, 0, 0, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    to_neg();
    chk("reset rd", 32'(rd), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset m_last", 32'(m_last), 32'd0);
    chk("reset m_data", 32'(m_data), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    finish_cycle();

    // Scenario 1: threshold-started burst of 4, then a kicked second burst.
    for (int b = 1; b <= 10; b++) push(8'(b));
    for (int i = 0; i < 14; i++) begin
      kick    = vec[i].kick;
      m_ready = vec[i].rdy;
      to_neg();
      chk($sformatf("s1 row %0d {rd,busy,valid,last,data}", i),
          32'({rd, busy, m_valid, m_valid & m_last, m_valid ? m_data : 8'h00}),
          32'({vec[i].rd, vec[i].busy, vec[i].valid, vec[i].last, vec[i].data}));
      finish_cycle();
    end
    kick = 1'b0;
    flush();
    rx_q.delete();

    // Scenario 2: burst_len 0 means a 16-beat burst.
    burst_len = 5'd0;
    for (int b = 0; b < 16; b++) push(8'(8'h10 + b));
    wait_beats("s2", 16, 60, 4'hF);
    check_rx("s2", 8'h10, 16);
    rx_q.delete();

    // Scenario 3: kicked burst runs dry, stalls, then resumes.
    chk("s3 stall_cnt before", 32'(stall_cnt), 32'd0);
    burst_len = 5'd5;
    push(8'h21);
    push(8'h22);
    push(8'h23);
    kick = 1'b1;
    cycle();
    kick = 1'b0;
    repeat (7) cycle();
    chk("s3 stall_cnt after pause", 32'(stall_cnt), 32'd4);
    chk("s3 busy while paused", 32'(busy), 32'd1);
    chk("s3 beats before refill", 32'(rx_q.size()), 32'd3);
    push(8'h24);
    push(8'h25);
    wait_beats("s3", 5, 30, 4'hF);
    check_rx("s3", 8'h21, 5);
    chk("s3 stall_cnt final", 32'(stall_cnt), 32'd4);
    rx_q.delete();

    // Scenario 4: ready pattern 1,0,0,1 during a 6-beat burst.
    burst_len = 5'd6;
    hold_seen = 0;
    for (int b = 0; b < 8; b++) push(8'(8'h31 + b));
    wait_beats("s4", 6, 60, 4'b1001);
    check_rx("s4", 8'h31, 6);
    chk("s4 backpressure exercised", 32'(hold_seen > 0), 32'd1);
    chk("s4 fifo words left", 32'(fifo_q.size()), 32'd2);
    flush();
    rx_q.delete();
`ifdef FIFO_READER_STATS_EN
    chk("beat_cnt after s1-s4", 32'(beat_cnt), 32'd35);
`endif

    // Scenario 5: reset after two beats of an 8-beat burst.
    burst_len = 5'd8;
    for (int b = 0; b < 10; b++) push(8'(8'h41 + b));
    for (int k = 0; k < 20 && rx_q.size() < 2; k++) cycle();
    chk("s5 two beats seen", 32'(rx_q.size()), 32'd2);
    rst = 1'b1;
    to_neg();
    chk("s5 rd during reset", 32'(rd), 32'd0);
    finish_cycle();
    rst = 1'b0;
    chk("s5 busy after reset", 32'(busy), 32'd0);
    chk("s5 m_valid after reset", 32'(m_valid), 32'd0);
    chk("s5 m_last after reset", 32'(m_last), 32'd0);
    chk("s5 m_data after reset", 32'(m_data), 32'd0);
    chk("s5 stall_cnt after reset", 32'(stall_cnt), 32'd0);
    repeat (5) begin
      to_neg();
      chk("s5 rd idle", 32'(rd), 32'd0);
      chk("s5 busy idle", 32'(busy), 32'd0);
      finish_cycle();
    end
    chk("s5 fifo words left", 32'(fifo_q.size()), 32'd7);
    flush();
    rx_q.delete();

    // Scenario 6: kick with an empty FIFO must not start a burst.
    kick = 1'b1;
    repeat (5) begin
      to_neg();
      chk("s6 rd", 32'(rd), 32'd0);
      chk("s6 busy", 32'(busy), 32'd0);
      finish_cycle();
    end
    kick = 1'b0;
    chk("s6 no beats", 32'(rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
